// File: rtl/task_3_pkg.sv
// Shared types and helpers for the task_3 latency probe blocks.
//   state_e   : probe generator FSM states
//   lat_width : latency counter width, a whole number of payload-width units
package task_3_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StProbe,
        StWait,
        StGap
    } state_e;

    // Latency counters are sized in units of the probe payload width.
    function automatic int unsigned lat_width(input int unsigned data_width,
                                              input int unsigned lat_size_in_width);
        return data_width * lat_size_in_width;
    endfunction

endpackage

// File: rtl/task_3_latency_probe_gen_if.sv
// Probe/response link between the latency probe generator and the DUT under measurement.
//   in_enb    : 1-cycle probe pulse towards the DUT
//   in_data   : probe payload (sequence number)
//   out_valid : DUT response level; its rising edge is the response
// master = probe generator side, slave = DUT side.
interface task_3_latency_probe_gen_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();

    logic                  in_enb;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;

    modport master (
        output in_enb,
        output in_data,
        input  out_valid
    );

    modport slave (
        input  in_enb,
        input  in_data,
        output out_valid
    );

endinterface

// File: rtl/task_3_rise_det.sv
// Registered rising-edge detector.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (history register cleared to 0)
//   d_i    : level input
//   rise_o : high in the cycle where d_i is 1 and was 0 in the previous cycle
module task_3_rise_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/task_3_latency_probe_gen.sv
// Latency probe generator: issues numbered probe pulses to a DUT, times each response
// (rising edge of out_valid) and tracks last/min/max latency plus a sticky timeout flag.
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_start            : run start pulse (ignored while busy)
//   i_num_probes       : probes per run, sampled at start
//   i_gap              : idle cycles after each response/timeout, sampled at start
//   probe_if (master)  : in_enb / in_data out to the DUT, out_valid back
//   o_lat, o_lat_valid : last measured latency and its update pulse
//   o_lat_min/max      : extremes over the current run
//   o_busy, o_done     : run in progress / end-of-run pulse
//   o_timeout          : sticky, some probe of this run got no response
// Optional: define TASK_3_LATPROBE_ACC_EN to add o_lat_sum (sum of latencies) and
// o_resp_cnt (response count), both cleared at run start.
module task_3_latency_probe_gen
    import task_3_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned LAT_SIZE_IN_WIDTH = 3,
    parameter int unsigned TIMEOUT           = 1000
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_start,
    input  logic [7:0]                        i_num_probes,
    input  logic [7:0]                        i_gap,
    task_3_latency_probe_gen_if.master        probe_if,
    output logic [lat_width(DATA_WIDTH, LAT_SIZE_IN_WIDTH)-1:0] o_lat,
    output logic                              o_lat_valid,
    output logic [lat_width(DATA_WIDTH, LAT_SIZE_IN_WIDTH)-1:0] o_lat_min,
    output logic [lat_width(DATA_WIDTH, LAT_SIZE_IN_WIDTH)-1:0] o_lat_max,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_timeout
`ifdef TASK_3_LATPROBE_ACC_EN
    ,
    output logic [lat_width(DATA_WIDTH, LAT_SIZE_IN_WIDTH)+7:0] o_lat_sum,
    output logic [7:0]                        o_resp_cnt
`endif
);

    localparam int unsigned LW = lat_width(DATA_WIDTH, LAT_SIZE_IN_WIDTH);
    localparam logic [LW-1:0] TimeoutLw = LW'(TIMEOUT);

    state_e                state_q, state_d;
    logic [LW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] seq_q, seq_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [7:0]            remain_q, remain_d;
    logic [7:0]            gap_q, gap_d;
    logic [7:0]            gcnt_q, gcnt_d;
    logic [LW-1:0]         lat_q, lat_d;
    logic                  lat_valid_q, lat_valid_d;
    logic [LW-1:0]         min_q, min_d;
    logic [LW-1:0]         max_q, max_d;
    logic                  done_q, done_d;
    logic                  timeout_q, timeout_d;

    logic                  rise;
    logic [LW-1:0]         lat_inc;
    logic                  run_start;

    task_3_rise_det u_rise_det (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .d_i    (probe_if.out_valid),
        .rise_o (rise)
    );

    // Latency if the response lands this cycle; saturates at all ones.
    assign lat_inc   = (cnt_q == '1) ? cnt_q : cnt_q + LW'(1);
    assign run_start = (state_q == StIdle) && i_start;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seq_d       = seq_q;
        data_d      = data_q;
        remain_d    = remain_q;
        gap_d       = gap_q;
        gcnt_d      = gcnt_q;
        lat_d       = lat_q;
        lat_valid_d = 1'b0;
        min_d       = min_q;
        max_d       = max_q;
        done_d      = 1'b0;
        timeout_d   = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    min_d     = '1;
                    max_d     = '0;
                    timeout_d = 1'b0;
                    seq_d     = '0;
                    if (i_num_probes == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        remain_d = i_num_probes;
                        gap_d    = i_gap;
                        data_d   = '0;
                        state_d  = StProbe;
                    end
                end
            end

            StProbe: begin
                cnt_d   = '0;
                state_d = StWait;
            end

            StWait: begin
                // A response on the timeout cycle itself still counts as a response.
                if (rise || (lat_inc >= TimeoutLw)) begin
                    if (rise) begin
                        lat_d       = lat_inc;
                        lat_valid_d = 1'b1;
                        if (lat_inc < min_q) min_d = lat_inc;
                        if (lat_inc > max_q) max_d = lat_inc;
                    end else begin
                        timeout_d = 1'b1;
                    end
                    seq_d    = seq_q + DATA_WIDTH'(1);
                    remain_d = remain_q - 8'd1;
                    gcnt_d   = '0;
                    state_d  = StGap;
                end else begin
                    cnt_d = lat_inc;
                end
            end

            StGap: begin
                // Stays max(1, gap) cycles: the GAP state itself is the minimum dead cycle.
                if (({1'b0, gcnt_q} + 9'd1) >= {1'b0, gap_q}) begin
                    if (remain_q != 8'd0) begin
                        data_d  = seq_q;
                        state_d = StProbe;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    gcnt_d = gcnt_q + 8'd1;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            seq_q       <= '0;
            data_q      <= '0;
            remain_q    <= '0;
            gap_q       <= '0;
            gcnt_q      <= '0;
            lat_q       <= '0;
            lat_valid_q <= 1'b0;
            min_q       <= '1;
            max_q       <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seq_q       <= seq_d;
            data_q      <= data_d;
            remain_q    <= remain_d;
            gap_q       <= gap_d;
            gcnt_q      <= gcnt_d;
            lat_q       <= lat_d;
            lat_valid_q <= lat_valid_d;
            min_q       <= min_d;
            max_q       <= max_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    // Probe pulse decoded from state so a reset drops it without waiting for a clock.
    assign probe_if.in_enb  = (state_q == StProbe);
    assign probe_if.in_data = data_q;

    assign o_lat       = lat_q;
    assign o_lat_valid = lat_valid_q;
    assign o_lat_min   = min_q;
    assign o_lat_max   = max_q;
    assign o_busy      = (state_q != StIdle);
    assign o_done      = done_q;
    assign o_timeout   = timeout_q;

`ifdef TASK_3_LATPROBE_ACC_EN
    logic [LW+7:0] sum_q, sum_d;
    logic [7:0]    resp_q, resp_d;

    always_comb begin
        sum_d  = sum_q;
        resp_d = resp_q;
        if (run_start) begin
            sum_d  = '0;
            resp_d = '0;
        end else if (lat_valid_d) begin
            sum_d  = sum_q + {8'd0, lat_inc};
            resp_d = resp_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sum_q  <= '0;
            resp_q <= '0;
        end else begin
            sum_q  <= sum_d;
            resp_q <= resp_d;
        end
    end

    assign o_lat_sum  = sum_q;
    assign o_resp_cnt = resp_q;
`else
    // Accumulators not built; run_start only feeds them.
    logic unused_run_start;
    assign unused_run_start = run_start;
`endif

endmodule

// File: tb/tb_task_3_latency_probe_gen.sv
// Directed bench for task_3_latency_probe_gen with a responder model and scoreboards
// for probe payloads and reported latencies.
module tb_task_3_latency_probe_gen;
    import task_3_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned LSW = 3;
    localparam int unsigned TO = 20;
    localparam int unsigned LW = DW * LSW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    num;
    logic [7:0]    gap;
    logic [LW-1:0] lat, lat_min, lat_max;
    logic          lat_valid, busy, done, timeout;
`ifdef TASK_3_LATPROBE_ACC_EN
    logic [LW+7:0] lat_sum;
    logic [7:0]    resp_cnt;
`endif

    task_3_latency_probe_gen_if #(.DATA_WIDTH(DW)) probe_if ();

    task_3_latency_probe_gen #(
        .DATA_WIDTH        (DW),
        .LAT_SIZE_IN_WIDTH (LSW),
        .TIMEOUT           (TO)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_num_probes (num),
        .i_gap        (gap),
        .probe_if     (probe_if),
        .o_lat        (lat),
        .o_lat_valid  (lat_valid),
        .o_lat_min    (lat_min),
        .o_lat_max    (lat_max),
        .o_busy       (busy),
        .o_done       (done),
        .o_timeout    (timeout)
`ifdef TASK_3_LATPROBE_ACC_EN
        ,
        .o_lat_sum    (lat_sum),
        .o_resp_cnt   (resp_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int enb_cnt = 0;
    int latv_cnt = 0;
    int done_cnt = 0;
    int exp_lat[$];
    int exp_data[$];
    int plan[$];

    bit   resp_auto = 1'b1;
    logic resp_valid = 1'b0;
    logic man_valid = 1'b0;
    int   cd = 0;

    assign probe_if.out_valid = resp_auto ? resp_valid : man_valid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Latency 0 or beyond TO means the probe goes unanswered in time.
    task automatic program_probe(input int l, input int d);
        plan.push_back(l);
        exp_data.push_back(d);
        if (l >= 1 && l <= int'(TO)) exp_lat.push_back(l);
    endtask

    task automatic start_run(input int n, input int g);
        start = 1'b1;
        num   = 8'(n);
        gap   = 8'(g);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int base;
        int i;
        base = done_cnt;
        i = 0;
        while (done_cnt == base && i < max_cycles) begin
            tick();
            i++;
        end
        check("done_seen", done_cnt - base, 1);
    endtask

    // Responder: raises out_valid for one cycle, L cycles after the probe cycle.
    always begin
        @(negedge clk);
        if (resp_auto && probe_if.in_enb === 1'b1) begin
            if (plan.size() > 0) cd = plan.pop_front();
            else cd = 0;
        end
        @(posedge clk);
        #1;
        resp_valid = 1'b0;
        if (!resp_auto) begin
            cd = 0;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) resp_valid = 1'b1;
        end
    end

    // Output monitor and scoreboard pops.
    always @(negedge clk) begin
        if (probe_if.in_enb === 1'b1) begin
            enb_cnt++;
            if (exp_data.size() == 0) check("enb_unexpected", exp_data.size(), 1);
            else check("in_data", probe_if.in_data, exp_data.pop_front());
        end
        if (lat_valid === 1'b1) begin
            latv_cnt++;
            if (exp_lat.size() == 0) check("lat_unexpected", exp_lat.size(), 1);
            else check("lat", lat, exp_lat.pop_front());
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        int eb, lb, db, i;
        rst_n = 1'b0;
        start = 1'b0;
        num   = 8'd0;
        gap   = 8'd0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_enb", probe_if.in_enb, 0);
        check("rst_data", probe_if.in_data, 0);
        check("rst_lat", lat, 0);
        check("rst_lat_valid", lat_valid, 0);
        check("rst_min", lat_min, {LW{1'b1}});
        check("rst_max", lat_max, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        tick();

        // Four probes, constant latency 5.
        for (int k = 0; k < 4; k++) program_probe(5, k);
        eb = enb_cnt; lb = latv_cnt; db = done_cnt;
        start_run(4, 2);
        check("t1_busy", busy, 1);
        wait_done(300);
        tick(); tick(); tick();
        check("t1_enb", enb_cnt - eb, 4);
        check("t1_latv", latv_cnt - lb, 4);
        check("t1_done", done_cnt - db, 1);
        check("t1_min", lat_min, 5);
        check("t1_max", lat_max, 5);
        check("t1_to", timeout, 0);
        check("t1_busy_end", busy, 0);
`ifdef TASK_3_LATPROBE_ACC_EN
        check("t1_sum", lat_sum, 20);
        check("t1_resp", resp_cnt, 4);
`endif

        // Mixed latencies.
        program_probe(3, 0); program_probe(9, 1); program_probe(1, 2); program_probe(7, 3);
        lb = latv_cnt;
        start_run(4, 0);
        wait_done(300);
        check("t2_latv", latv_cnt - lb, 4);
        check("t2_min", lat_min, 1);
        check("t2_max", lat_max, 9);
        check("t2_lat", lat, 7);

        // Silent second probe.
        program_probe(4, 0); program_probe(0, 1); program_probe(6, 2);
        eb = enb_cnt; lb = latv_cnt;
        start_run(3, 1);
        wait_done(300);
        check("t3_to", timeout, 1);
        check("t3_latv", latv_cnt - lb, 2);
        check("t3_enb", enb_cnt - eb, 3);
        check("t3_lat", lat, 6);
        check("t3_min", lat_min, 4);
        check("t3_max", lat_max, 6);

        // Response exactly on the timeout cycle, then one cycle too late.
        program_probe(int'(TO), 0);
        start_run(1, 0);
        wait_done(100);
        check("t4a_to", timeout, 0);
        check("t4a_lat", lat, TO);
        program_probe(int'(TO) + 1, 0);
        lb = latv_cnt;
        start_run(1, 0);
        wait_done(100);
        tick(); tick();
        check("t4b_to", timeout, 1);
        check("t4b_lat_kept", lat, TO);
        check("t4b_latv", latv_cnt - lb, 0);
        check("t4b_min", lat_min, {LW{1'b1}});
        check("t4b_max", lat_max, 0);

        // out_valid already high when the probe goes out.
        resp_auto = 1'b0;
        man_valid = 1'b1;
        tick(); tick(); tick();
        exp_data.push_back(0);
        exp_lat.push_back(5);
        lb = latv_cnt;
        start_run(1, 0);
        tick(); tick();
        check("t5_no_early", latv_cnt - lb, 0);
        check("t5_busy", busy, 1);
        tick();
        man_valid = 1'b0;
        tick(); tick();
        man_valid = 1'b1;
        wait_done(100);
        man_valid = 1'b0;
        check("t5_lat", lat, 5);
        check("t5_latv", latv_cnt - lb, 1);
        check("t5_to", timeout, 0);
        resp_auto = 1'b1;
        tick();

        // Reset during the wait of probe 2.
        program_probe(4, 0); program_probe(50, 1); program_probe(3, 2);
        eb = enb_cnt; db = done_cnt;
        start_run(3, 0);
        i = 0;
        while (enb_cnt - eb < 2 && i < 200) begin
            tick();
            i++;
        end
        check("t6_probe2", enb_cnt - eb, 2);
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_enb", probe_if.in_enb, 0);
        check("t6_lat", lat, 0);
        check("t6_min", lat_min, {LW{1'b1}});
        check("t6_data", probe_if.in_data, 0);
        resp_auto = 1'b0;
        tick(); tick(); tick();
        check("t6_no_done", done_cnt - db, 0);
        plan.delete();
        exp_lat.delete();
        exp_data.delete();
        rst_n = 1'b1;
        tick();
        resp_auto = 1'b1;
        program_probe(2, 0); program_probe(3, 1);
        lb = latv_cnt;
        start_run(2, 0);
        wait_done(200);
        check("t6_rerun_latv", latv_cnt - lb, 2);
        check("t6_rerun_min", lat_min, 2);
        check("t6_rerun_max", lat_max, 3);

        // Zero-probe run.
        eb = enb_cnt; db = done_cnt;
        start_run(0, 0);
        check("t7_done", done, 1);
        check("t7_busy", busy, 0);
        check("t7_min", lat_min, {LW{1'b1}});
        check("t7_max", lat_max, 0);
        tick();
        check("t7_done_pulse", done, 0);
        tick(); tick(); tick();
        check("t7_enb", enb_cnt - eb, 0);
        check("t7_done_cnt", done_cnt - db, 1);

        check("lat_queue_empty", exp_lat.size(), 0);
        check("data_queue_empty", exp_data.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
